// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard and a registered pending count.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
`timescale 1ns/1ps

module regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              rs_busy,
   output logic              rt_busy,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] wn,
   input  logic [DATA_W-1:0] wd,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_dst,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - int'(ZERO_REG));

   logic [DATA_W-1:0] file_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_en, set_en, cnt_inc, cnt_dec;

   // Register 0 is read-only when hardwired, so both its writes and issues are dropped.
   always_comb begin
      wr_en  = RegWrite && !(ZERO_REG && (wn == '0));
      set_en = issue_valid && !(ZERO_REG && (issue_dst == '0));
   end

   // Set is applied after clear so a new producer wins over a retiring one.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[wn] = 1'b0;
      end
      if (set_en) begin
         busy_d[issue_dst] = 1'b1;
      end
   end

   // Count tracks popcount incrementally: +1 for a fresh set, -1 for a real clear.
   always_comb begin
      cnt_inc = set_en && !busy_q[issue_dst];
      cnt_dec = wr_en && busy_q[wn] && !(set_en && (issue_dst == wn));
      cnt_d   = cnt_q;
      if (cnt_inc && !cnt_dec) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (cnt_dec && !cnt_inc) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            file_q[i] <= '0;
         end
      end else if (wr_en) begin
         file_q[wn] <= wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rd1     = file_q[rs];
      rd2     = file_q[rt];
      rs_busy = busy_q[rs];
      rt_busy = busy_q[rt];
      if (ZERO_REG && (rs == '0)) begin
         rd1 = '0;
      end
      if (ZERO_REG && (rt == '0)) begin
         rd2 = '0;
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the post-edge view; gated by rst_n so reset still forces zeros.
      if (rst_n && wr_en && (wn == rs)) begin
         rd1     = wd;
         rs_busy = set_en && (issue_dst == rs);
      end
      if (rst_n && wr_en && (wn == rt)) begin
         rd2     = wd;
         rt_busy = set_en && (issue_dst == rt);
      end
`endif
   end

   assign busy_cnt = cnt_q;

   cnt_bound_a: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_MAX);
   cnt_popcount_a: assert property (@(posedge clk) disable iff (!rst_n)
                                    cnt_q == CNT_W'($countones(busy_q)));

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the register data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning the register address width, so depth = 2**ADDR_W.
REQ-003 The module SHALL have parameter ZERO_REG, default 1, meaning that 1 hardwires register 0 to zero and 0 makes register 0 a normal register.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 The module SHALL have ports rs, rt, input, ADDR_W bits, the read addresses for ports 1 and 2.
REQ-007 The module SHALL have ports rd1, rd2, output, DATA_W bits, the read data for rs and rt.
REQ-008 The module SHALL have ports rs_busy, rt_busy, output, 1 bit, the scoreboard pending flag for rs and rt.
REQ-009 The module SHALL have port RegWrite, input, 1 bit, the write enable.
REQ-010 The module SHALL have port wn, input, ADDR_W bits, the write address.
REQ-011 The module SHALL have port wd, input, DATA_W bits, the write data.
REQ-012 The module SHALL have port issue_valid, input, 1 bit, which marks the destination of a newly issued instruction as pending.
REQ-013 The module SHALL have port issue_dst, input, ADDR_W bits, the destination register being issued.
REQ-014 The module SHALL have port busy_cnt, output, ADDR_W+1 bits, the number of registers currently pending.

Function
REQ-015 The module SHALL hold 2**ADDR_W registers of DATA_W bits plus one busy bit per register.
REQ-016 The module SHALL write wd into file[wn] on the rising clk edge when RegWrite=1, except when ZERO_REG=1 and wn=0, in which case the write is dropped.
REQ-017 The module SHALL drive rd1=file[rs] and rd2=file[rt] combinationally, with zero cycles of latency.
REQ-018 The module SHALL return 0 on rd1/rd2 for address 0 when ZERO_REG=1, regardless of history.
REQ-019 The module SHALL set busy[issue_dst] at the rising edge when issue_valid=1, except when ZERO_REG=1 and issue_dst=0, in which case the bit is never set.
REQ-020 The module SHALL clear busy[wn] at the rising edge when RegWrite=1 and the write is not dropped.
REQ-021 The module SHALL let the set win when a set and a clear hit the same register in the same edge, so busy stays 1 (new producer in flight).
REQ-022 The module SHALL leave a bit at 1 when a set hits a register whose busy bit is already 1, with no error indication.
REQ-023 The module SHALL still perform a write to a non-busy register and leave its busy bit at 0.
REQ-024 The module SHALL drive rs_busy=busy[rs] and rt_busy=busy[rt] combinationally, modified only as stated in REQ-032.
REQ-025 The module SHALL keep busy_cnt registered and equal to the population count of the busy bits after each edge.
REQ-026 The module SHALL change busy_cnt by at most +1 or -1 per edge, and by 0 when set and clear hit the same register or cancel out.
REQ-027 The module SHALL never let busy_cnt exceed 2**ADDR_W - ZERO_REG, so no wrap-around occurs.

Reset
REQ-028 The module SHALL, while rst_n=0, asynchronously clear all file entries to 0, all busy bits to 0 and busy_cnt to 0.
REQ-029 The module SHALL, while in reset, output rd1=rd2=0, rs_busy=rt_busy=0 and busy_cnt=0.
REQ-030 The module SHALL discard any write or issue pending in the cycle that reset asserts, with no partial update.
REQ-031 The module SHALL accept its first write or issue at the first rising edge after rst_n deasserts.

Configuration
REQ-032 The module SHALL, when macro REGFILE_BYPASS_EN is defined, forward same-cycle writes: RegWrite=1 with wn=rs and the write not dropped gives rd1=wd and rs_busy=0 (same rule for rt/rd2/rt_busy), unless issue_valid=1 with issue_dst=rs in that same cycle, which keeps rs_busy=1.
REQ-033 The module SHALL, when REGFILE_BYPASS_EN is undefined, make rd1/rd2 and rs_busy/rt_busy show pre-edge state only, so a written value is visible the cycle after the write.

Verification
REQ-034 The bench SHALL apply reset then write wn=5, wd=0xDEADBEEF, and require rs=5 to read 0xDEADBEEF the next cycle with rs_busy=0.
REQ-035 The bench SHALL, with ZERO_REG=1, write wn=0, wd=0xFFFFFFFF plus issue_dst=0, and require rs=0 to read 0, rs_busy=0 and busy_cnt=0.
REQ-036 The bench SHALL issue r3 then r7 on consecutive cycles (busy_cnt=2, rs=3 gives rs_busy=1), then write r3, and require busy_cnt=1 and rs_busy=0.
REQ-037 The bench SHALL, in the same edge, apply issue_dst=9 and write wn=9, wd=0x12, and require busy[9]=1, file[9]=0x12 and busy_cnt unchanged if r9 was already busy.
REQ-038 The bench SHALL, with REGFILE_BYPASS_EN defined and rs=4, write wn=4, wd=0xA5A5A5A5, and require rd1=0xA5A5A5A5 in the write cycle; without the macro, rd1 shows the old value in that cycle.
REQ-039 The bench SHALL, after filling r1..r6 and issuing r1..r6, pulse rst_n low mid-cycle, and require all reads=0, busy flags=0 and busy_cnt=0 immediately, before the next clk edge.
